// File: rtl/input_conditioner.sv
// Pushbutton/switch front-end: per-button synchronizer + debounce with press/release pulses,
// and a plain two-flop synchronizer for the switch bus.

module input_conditioner_ch #(
  parameter int DEB_CYCLES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);
  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_lvl;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          r_release;
  logic          w_s2;
  logic          w_flip;

  assign w_s2   = r_sync[1];
  // The counter only reaches CMAX while s2 disagrees with lvl, so hitting it means "flip now".
  assign w_flip = (w_s2 != r_lvl) && (r_cnt == CMAX);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync    <= '0;
      r_lvl     <= 1'b0;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_raw};
      r_press   <= w_flip &  w_s2;
      r_release <= w_flip & ~w_s2;
      if (w_s2 == r_lvl) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_lvl <= w_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level   = r_lvl;
  assign o_press   = r_press;
  assign o_release = r_release;
endmodule

module input_conditioner #(
  parameter int NUM_BTN    = 3,
  parameter int DEB_CYCLES = 2,
  parameter int SW_WIDTH   = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NUM_BTN-1:0]  btn_in,
  input  logic [SW_WIDTH-1:0] sw_in,
  output logic [NUM_BTN-1:0]  btn_level,
  output logic [NUM_BTN-1:0]  btn_press,
  output logic [NUM_BTN-1:0]  btn_release,
  output logic [SW_WIDTH-1:0] sw_sync
);
  logic [1:0][SW_WIDTH-1:0] r_sw;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    input_conditioner_ch #(.DEB_CYCLES(DEB_CYCLES)) u_ch (
      .Clk      (Clk),
      .Reset    (Reset),
      .i_raw    (btn_in[g]),
      .o_level  (btn_level[g]),
      .o_press  (btn_press[g]),
      .o_release(btn_release[g])
    );
  end

  // Switches are sampled by the consumer only on a press, so per-bit skew is harmless.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_sw <= '0;
    else       r_sw <= {r_sw[0], sw_in};
  end

  assign sw_sync = r_sw[1];
endmodule

// File: tb/tb_input_conditioner.sv
// Directed-vector bench for input_conditioner with default parameters (3 buttons, debounce 2, 8 switches).

module tb_input_conditioner;
  logic       Clk = 1'b0;
  logic       Reset;
  logic [2:0] btn_in;
  logic [7:0] sw_in;
  logic [2:0] btn_level, btn_press, btn_release;
  logic [7:0] sw_sync;

  int n_chk = 0;
  int n_err = 0;

  input_conditioner dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .btn_in     (btn_in),
    .sw_in      (sw_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .sw_sync    (sw_sync)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [7:0] pat;
    Reset  = 1'b1;
    btn_in = '0;
    sw_in  = '0;

    // Reset state and glitch rejection
    tick(); tick(); tick();
    chk("rst_level",   btn_level,   3'b000);
    chk("rst_press",   btn_press,   3'b000);
    chk("rst_release", btn_release, 3'b000);
    chk("rst_sw",      sw_sync,     8'h00);
    Reset  = 1'b0;
    btn_in = 3'b001;
    tick();
    btn_in = 3'b000;
    chk("glitch_lvl0", btn_level[0], 1'b0);
    chk("glitch_prs0", btn_press[0], 1'b0);
    for (int e = 2; e <= 7; e++) begin
      tick();
      chk("glitch_lvl", btn_level[0], 1'b0);
      chk("glitch_prs", btn_press[0], 1'b0);
    end

    // Clean press held 10 cycles, then release
    btn_in = 3'b001;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("press_lvl", btn_level[0], (e >= 4) ? 1'b1 : 1'b0);
      chk("press_prs", btn_press[0], (e == 4) ? 1'b1 : 1'b0);
      chk("press_rel", btn_release[0], 1'b0);
    end
    btn_in = 3'b000;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("rel_lvl", btn_level[0], (e < 4) ? 1'b1 : 1'b0);
      chk("rel_rel", btn_release[0], (e == 4) ? 1'b1 : 1'b0);
      chk("rel_prs", btn_press[0], 1'b0);
    end

    // Bouncing press on channel 1: 1,0,1,0,1,1,1,1
    pat = 8'b1111_0101;
    for (int e = 1; e <= 12; e++) begin
      btn_in[1] = (e <= 8) ? pat[e-1] : 1'b1;
      tick();
      chk("bounce_prs", btn_press,   (e == 8) ? 3'b010 : 3'b000);
      chk("bounce_lvl", btn_level,   (e >= 8) ? 3'b010 : 3'b000);
      chk("bounce_rel", btn_release, 3'b000);
    end
    btn_in = 3'b000;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("b_rel_rel", btn_release, (e == 4) ? 3'b010 : 3'b000);
    end

    // Simultaneous presses on channels 0 and 2
    btn_in = 3'b101;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("simul_prs", btn_press, (e == 4) ? 3'b101 : 3'b000);
      chk("simul_lvl", btn_level, (e >= 4) ? 3'b101 : 3'b000);
    end
    btn_in = 3'b000;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("simul_rel", btn_release, (e == 4) ? 3'b101 : 3'b000);
      chk("simul_rp",  btn_press, 3'b000);
    end

    // Switch synchronizer latency
    sw_in = 8'h33;
    tick(); chk("sw_e1", sw_sync, 8'h00);
    tick(); chk("sw_e2", sw_sync, 8'h33);
    sw_in = 8'h55;
    tick(); chk("sw_e3", sw_sync, 8'h33);
    tick(); chk("sw_e4", sw_sync, 8'h55);

    // Mid-cycle reset with channel 2 held
    btn_in = 3'b100;
    for (int e = 1; e <= 5; e++) tick();
    chk("held_lvl2", btn_level, 3'b100);
    #2;
    Reset = 1'b1;
    #1;
    chk("mrst_lvl", btn_level,   3'b000);
    chk("mrst_prs", btn_press,   3'b000);
    chk("mrst_rel", btn_release, 3'b000);
    chk("mrst_sw",  sw_sync,     8'h00);
    #1;
    Reset = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk("post_prs", btn_press,   (e == 4) ? 3'b100 : 3'b000);
      chk("post_rel", btn_release, 3'b000);
      chk("post_lvl", btn_level,   (e >= 4) ? 3'b100 : 3'b000);
      chk("post_sw",  sw_sync,     (e >= 2) ? 8'h55 : 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
